md_ctrl: RTL

MD_CTRL -- requirements
Module: md_ctrl

---
 rtl/md_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/md_ctrl.sv
// Multiply/divide unit: multi-cycle HI/LO control with stall generation.
// Results are computed at the start edge and committed once the busy period ends.
module md_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  E_md_op,
   input  logic [31:0] E_rs,
   input  logic [31:0] E_rt,
   input  logic        D_md_use,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        md_stall
);

   localparam int unsigned MaxCyc = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CntW   = $clog2(MaxCyc + 1);
   localparam logic [CntW-1:0] MultCnt = CntW'(MULT_CYCLES);
   localparam logic [CntW-1:0] DivCnt  = CntW'(DIV_CYCLES);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);

   typedef enum logic [1:0] {StIdle, StMult, StDiv} state_e;

   state_e            r_state, w_state_nxt;
   logic [CntW-1:0]   r_cnt, w_cnt_nxt;
   logic [31:0]       r_hi, w_hi_nxt;
   logic [31:0]       r_lo, w_lo_nxt;
   logic [31:0]       r_res_hi, w_res_hi_nxt;
   logic [31:0]       r_res_lo, w_res_lo_nxt;
   logic              r_div0, w_div0_nxt;

   logic [63:0]        w_prod_s, w_prod_u;
   logic [31:0]        w_dvs;
   logic signed [32:0] w_sa, w_sb;
   logic [31:0]        w_sq, w_sr, w_uq, w_ur;
   logic               w_is_start;

   assign w_prod_s = {{32{E_rs[31]}}, E_rs} * {{32{E_rt[31]}}, E_rt};
   assign w_prod_u = {32'd0, E_rs} * {32'd0, E_rt};

   // Divisor forced to 1 on zero so the dividers never see /0; the result is discarded anyway.
   assign w_dvs = (E_rt == 32'd0) ? 32'd1 : E_rt;
   // 33-bit signed operands keep 0x80000000 / -1 representable (lower 32 bits give 0x80000000).
   assign w_sa  = {E_rs[31], E_rs};
   assign w_sb  = {w_dvs[31], w_dvs};
   assign w_sq  = 32'(w_sa / w_sb);
   assign w_sr  = 32'(w_sa % w_sb);
   assign w_uq  = E_rs / w_dvs;
   assign w_ur  = E_rs % w_dvs;

   assign w_is_start = (E_md_op >= 3'd1) && (E_md_op <= 3'd4);
   assign busy       = (r_state != StIdle);
   assign md_stall   = D_md_use & (busy | w_is_start);
   assign hi         = r_hi;
   assign lo         = r_lo;

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_hi_nxt     = r_hi;
      w_lo_nxt     = r_lo;
      w_res_hi_nxt = r_res_hi;
      w_res_lo_nxt = r_res_lo;
      w_div0_nxt   = r_div0;
      unique case (r_state)
         StIdle: begin
            case (E_md_op)
               3'd1, 3'd2: begin
                  w_res_hi_nxt = (E_md_op == 3'd1) ? w_prod_s[63:32] : w_prod_u[63:32];
                  w_res_lo_nxt = (E_md_op == 3'd1) ? w_prod_s[31:0]  : w_prod_u[31:0];
                  w_div0_nxt   = 1'b0;
                  w_cnt_nxt    = MultCnt;
                  w_state_nxt  = StMult;
               end
               3'd3, 3'd4: begin
                  w_res_hi_nxt = (E_md_op == 3'd3) ? w_sr : w_ur;
                  w_res_lo_nxt = (E_md_op == 3'd3) ? w_sq : w_uq;
                  w_div0_nxt   = (E_rt == 32'd0);
                  w_cnt_nxt    = DivCnt;
                  w_state_nxt  = StDiv;
               end
               3'd5:    w_hi_nxt = E_rs;
               3'd6:    w_lo_nxt = E_rs;
               default: ;
            endcase
         end
         StMult, StDiv: begin
            w_cnt_nxt = r_cnt - CntOne;
            if (r_cnt <= CntOne) begin
               w_state_nxt = StIdle;
               w_cnt_nxt   = '0;
               if (!r_div0) begin
                  w_hi_nxt = r_res_hi;
                  w_lo_nxt = r_res_lo;
               end
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= StIdle;
         r_cnt    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_res_hi <= '0;
         r_res_lo <= '0;
         r_div0   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_hi     <= w_hi_nxt;
         r_lo     <= w_lo_nxt;
         r_res_hi <= w_res_hi_nxt;
         r_res_lo <= w_res_lo_nxt;
         r_div0   <= w_div0_nxt;
      end
   end

endmodule
